// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with hold, flush, canonical zero bubbles and
// saturating bubble/stall performance counters.
module pipe_stage_reg #(
    parameter int NUM_WORDS = 5,
    parameter int WORD_W    = 32,
    parameter int WA_W      = 5,
    parameter int INSTR_IDX = 4,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        clr,
    input  logic                        valid_in,
    input  logic [NUM_WORDS*WORD_W-1:0] data_in,
    input  logic [WA_W-1:0]             wa_in,
    input  logic                        cnt_clr,
    output logic                        valid_out,
    output logic [NUM_WORDS*WORD_W-1:0] data_out,
    output logic [WA_W-1:0]             wa_out,
    output logic [4:0]                  shamt,
    output logic [CNT_W-1:0]            bubble_cnt,
    output logic [CNT_W-1:0]            stall_cnt
);

    localparam int DATA_W = NUM_WORDS * WORD_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    generate
        if (INSTR_IDX >= NUM_WORDS || WORD_W < 11) begin : g_bad_params
            $error("pipe_stage_reg: INSTR_IDX must be < NUM_WORDS and WORD_W >= 11");
        end
    endgenerate

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [WA_W-1:0]   wa_q, wa_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              bubble_load;
    logic              stall_edge;

    always_comb begin
        // NOTE: every variable gets a default first so no path through the
        // block leaves it unassigned; otherwise a latch is inferred.
        valid_d      = valid_q;
        data_d       = data_q;
        wa_d         = wa_q;
        bubble_cnt_d = bubble_cnt_q;
        stall_cnt_d  = stall_cnt_q;

        bubble_load = clr | (en & ~valid_in);
        stall_edge  = ~clr & ~en & valid_q;

        // Bubbles are always all-zero so a held bubble never matches a forward.
        if (bubble_load) begin
            valid_d = 1'b0;
            data_d  = '0;
            wa_d    = '0;
        end else if (en) begin
            valid_d = 1'b1;
            data_d  = data_in;
            wa_d    = wa_in;
        end

        if (cnt_clr) begin
            bubble_cnt_d = '0;
            stall_cnt_d  = '0;
        end else begin
            if (bubble_load && bubble_cnt_q != CNT_MAX)
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            if (stall_edge && stall_cnt_q != CNT_MAX)
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            valid_q      <= 1'b0;
            data_q       <= '0;
            wa_q         <= '0;
            bubble_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            data_q       <= data_d;
            wa_q         <= wa_d;
            bubble_cnt_q <= bubble_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign valid_out  = valid_q;
    assign data_out   = data_q;
    assign wa_out     = wa_q;
    assign shamt      = data_q[INSTR_IDX*WORD_W+6 +: 5];
    assign bubble_cnt = bubble_cnt_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a driver pushes model predictions, a
// monitor pops and compares after every clock edge.
module tb_pipe_stage_reg;

    localparam int NW  = 5;
    localparam int WW  = 32;
    localparam int WAW = 5;
    localparam int IDX = 4;
    localparam int CW  = 16;
    localparam int CWS = 2;
    localparam int DW  = NW * WW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en = 1'b0;
    logic           clr = 1'b0;
    logic           valid_in = 1'b0;
    logic           cnt_clr = 1'b0;
    logic [DW-1:0]  data_in = '0;
    logic [WAW-1:0] wa_in = '0;

    logic           valid_out, valid_out_s;
    logic [DW-1:0]  data_out, data_out_s;
    logic [WAW-1:0] wa_out, wa_out_s;
    logic [4:0]     shamt, shamt_s;
    logic [CW-1:0]  bubble_cnt, stall_cnt;
    logic [CWS-1:0] bubble_cnt_s, stall_cnt_s;

    pipe_stage_reg #(.NUM_WORDS(NW), .WORD_W(WW), .WA_W(WAW), .INSTR_IDX(IDX), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .valid_in(valid_in),
        .data_in(data_in), .wa_in(wa_in), .cnt_clr(cnt_clr),
        .valid_out(valid_out), .data_out(data_out), .wa_out(wa_out), .shamt(shamt),
        .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
    );

    // Narrow-counter copy driven identically, to reach saturation quickly.
    pipe_stage_reg #(.NUM_WORDS(NW), .WORD_W(WW), .WA_W(WAW), .INSTR_IDX(IDX), .CNT_W(CWS)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .valid_in(valid_in),
        .data_in(data_in), .wa_in(wa_in), .cnt_clr(cnt_clr),
        .valid_out(valid_out_s), .data_out(data_out_s), .wa_out(wa_out_s), .shamt(shamt_s),
        .bubble_cnt(bubble_cnt_s), .stall_cnt(stall_cnt_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           valid;
        logic [DW-1:0]  data;
        logic [WAW-1:0] wa;
        logic [4:0]     shamt;
        longint         bub;
        longint         stl;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: plain stage contents plus unbounded event counts.
    logic           m_valid = 1'b0;
    logic [DW-1:0]  m_data  = '0;
    logic [WAW-1:0] m_wa    = '0;
    longint         m_bub   = 0;
    longint         m_stl   = 0;

    function automatic longint sat(longint v, int w);
        longint mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < NW; i++) d[i*WW +: WW] = $urandom;
        return d;
    endfunction

    task automatic step(input bit r, input bit e, input bit c, input bit v, input bit cc,
                        input logic [DW-1:0] d, input logic [WAW-1:0] w);
        exp_t x;
        logic [WW-1:0] iw;
        @(negedge clk);
        rst = r; en = e; clr = c; valid_in = v; cnt_clr = cc; data_in = d; wa_in = w;
        if (r) begin
            m_valid = 1'b0; m_data = '0; m_wa = '0; m_bub = 0; m_stl = 0;
        end else begin
            bit is_bubble = c || (e && !v);
            bit is_stall  = !c && !e && m_valid;
            if (is_bubble) begin
                m_valid = 1'b0; m_data = '0; m_wa = '0;
            end else if (e) begin
                m_valid = 1'b1; m_data = d; m_wa = w;
            end
            if (cc) begin
                m_bub = 0; m_stl = 0;
            end else begin
                m_bub += longint'(is_bubble);
                m_stl += longint'(is_stall);
            end
        end
        iw      = m_data[IDX*WW +: WW];
        x.valid = m_valid;
        x.data  = m_data;
        x.wa    = m_wa;
        x.shamt = 5'((iw >> 6) & 32'h1f);
        x.bub   = m_bub;
        x.stl   = m_stl;
        sb_q.push_back(x);
    endtask

    initial begin
        forever begin
            exp_t x;
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                check("valid_out", DW'(valid_out), DW'(x.valid));
                check("data_out", data_out, x.data);
                check("wa_out", DW'(wa_out), DW'(x.wa));
                check("shamt", DW'(shamt), DW'(x.shamt));
                check("bubble_cnt", DW'(bubble_cnt), DW'(sat(x.bub, CW)));
                check("stall_cnt", DW'(stall_cnt), DW'(sat(x.stl, CW)));
                check("sat.valid_out", DW'(valid_out_s), DW'(x.valid));
                check("sat.data_out", data_out_s, x.data);
                check("sat.wa_out", DW'(wa_out_s), DW'(x.wa));
                check("sat.shamt", DW'(shamt_s), DW'(x.shamt));
                check("sat.bubble_cnt", DW'(bubble_cnt_s), DW'(sat(x.bub, CWS)));
                check("sat.stall_cnt", DW'(stall_cnt_s), DW'(sat(x.stl, CWS)));
            end
        end
    end

    initial begin
        logic [DW-1:0] ones;
        logic [DW-1:0] first;
        ones  = '1;
        first = {32'h00021080, 32'h00003008, 32'h33333333, 32'h22222222, 32'h11111111};

        // Reset, then a first load with shamt=2.
        step(1, 0, 0, 0, 0, '0, '0);
        step(1, 0, 0, 0, 0, '0, '0);
        step(0, 1, 0, 1, 0, first, 5'd5);

        // Stall for three edges with changing inputs, then advance.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, rand_data(), 5'($urandom));
        step(0, 1, 0, 1, 0, rand_data(), 5'd9);

        // Flush during a stall, then invalid input with all-ones data.
        step(0, 0, 1, 1, 0, rand_data(), 5'd7);
        step(0, 1, 0, 1, 0, rand_data(), 5'd3);
        step(0, 1, 0, 0, 0, ones, 5'd31);

        // Saturate the narrow bubble counter, then clear alongside a flush.
        for (int i = 0; i < 6; i++) step(0, 1, 1, 1, 0, rand_data(), 5'($urandom));
        step(0, 1, 1, 1, 1, rand_data(), 5'd1);

        // Reset in the middle of a four-edge stall, then a normal load.
        step(0, 1, 0, 1, 1, rand_data(), 5'd12);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, rand_data(), 5'($urandom));
        step(1, 0, 0, 1, 0, rand_data(), 5'd4);
        step(0, 1, 0, 1, 0, rand_data(), 5'd17);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 31) == 0,
                 rand_data(), 5'($urandom));
        end

        repeat (2) @(posedge clk);
        #2;
        check("scoreboard_drained", DW'(sb_q.size()), DW'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
